// File: rtl/mc_ctrl_fsm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_ctrl_fsm_pkg : states, writeback selects, instruction classes
//                   and opcode constants for the multicycle control
// Rev 1.0
// ------------------------------------------------------------------
package mc_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        ST_F   = 3'd0,
        ST_D   = 3'd1,
        ST_E   = 3'd2,
        ST_M   = 3'd3,
        ST_W   = 3'd4,
        ST_ERR = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_t;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_JUMP    = 3'd1,
        CLS_JAL     = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_ALU     = 3'd4,
        CLS_LOAD    = 3'd5,
        CLS_STORE   = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_t;

    localparam logic [5:0] F6_RTYPE = 6'h00;
    localparam logic [5:0] F6_J     = 6'h02;
    localparam logic [5:0] F6_JAL   = 6'h03;
    localparam logic [5:0] F6_BEQ   = 6'h04;
    localparam logic [5:0] F6_BNE   = 6'h05;
    localparam logic [5:0] F6_ADDI  = 6'h08;
    localparam logic [5:0] F6_ORI   = 6'h0D;
    localparam logic [5:0] F6_LUI   = 6'h0F;
    localparam logic [5:0] F6_LW    = 6'h23;
    localparam logic [5:0] F6_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam int unsigned N_STAGES = 5;

    // ERR deliberately maps to all-zero so nothing in the datapath advances.
    function automatic logic [N_STAGES-1:0] stage_onehot(input ctrl_state_t s);
        logic [N_STAGES-1:0] en;
        en = '0;
        case (s)
            ST_F:    en = 5'b00001;
            ST_D:    en = 5'b00010;
            ST_E:    en = 5'b00100;
            ST_M:    en = 5'b01000;
            ST_W:    en = 5'b10000;
            default: en = 5'b00000;
        endcase
        return en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_ctrl_fsm_if : memory handshake and datapath control bundle
// Rev 1.0
// ------------------------------------------------------------------
interface mc_ctrl_fsm_if #(
    parameter int unsigned CNT_W = 32
) ();

    logic             imem_resp_valid;
    logic [31:0]      imem_resp_data;
    logic             dmem_resp_valid;
    logic             imem_req;
    logic             dmem_req;
    logic [31:0]      ir;
    logic [4:0]       stage_en;
    logic [1:0]       wb_sel;
    logic             retire;
    logic             illegal;
    logic             err;
    logic [CNT_W-1:0] cnt_cycle;
    logic [CNT_W-1:0] cnt_instret;

    modport master (
        input  imem_resp_valid, imem_resp_data, dmem_resp_valid,
        output imem_req, dmem_req, ir, stage_en, wb_sel,
               retire, illegal, err, cnt_cycle, cnt_instret
    );

    modport slave (
        output imem_resp_valid, imem_resp_data, dmem_resp_valid,
        input  imem_req, dmem_req, ir, stage_en, wb_sel,
               retire, illegal, err, cnt_cycle, cnt_instret
    );

endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm_instr_class.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_instr_class : combinational opcode/func classifier with legality
// Rev 1.0
// ------------------------------------------------------------------
module mc_instr_class
    import mc_ctrl_fsm_pkg::*;
#(
    parameter bit EN_JAL = 1'b1
) (
    input  logic [31:0]  ir_i,
    output instr_class_t cls_o,
    output logic         legal_o
);

    logic [5:0] w_op;
    logic [5:0] w_fn;

    assign w_op = ir_i[31:26];
    assign w_fn = ir_i[5:0];

    always_comb begin
        cls_o   = CLS_ILLEGAL;
        legal_o = 1'b0;
        // The all-zero word is an SLL encoding, but it is treated as a NOP ahead of R-type decode.
        if (ir_i == 32'h0) begin
            cls_o = CLS_NOP;
        end else begin
            case (w_op)
                F6_RTYPE: begin
                    case (w_fn)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: cls_o = CLS_ALU;
                        default:                               cls_o = CLS_ILLEGAL;
                    endcase
                end
                F6_J:                     cls_o = CLS_JUMP;
                F6_JAL:                   cls_o = EN_JAL ? CLS_JAL : CLS_ILLEGAL;
                F6_BEQ, F6_BNE:           cls_o = CLS_BRANCH;
                F6_ADDI, F6_ORI, F6_LUI:  cls_o = CLS_ALU;
                F6_LW:                    cls_o = CLS_LOAD;
                F6_SW:                    cls_o = CLS_STORE;
                default:                  cls_o = CLS_ILLEGAL;
            endcase
        end
        legal_o = (cls_o != CLS_ILLEGAL);
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_ctrl_fsm : multicycle F/D/E/M/W sequencer with memory handshakes,
//               wait timeout, sticky error and performance counters
// Rev 1.0
// ------------------------------------------------------------------
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter bit          EN_JAL  = 1'b1,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_ctrl_fsm_if.master    ctrl_if
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    ctrl_state_t      state_q,       state_d;
    logic [31:0]      ir_q,          ir_d;
    wb_sel_t          wb_sel_q,      wb_sel_d;
    logic             retire_q,      retire_d;
    logic             illegal_q,     illegal_d;
    logic             err_q,         err_d;
    logic [WAIT_W-1:0] wait_q,       wait_d;
    logic [CNT_W-1:0] cnt_cycle_q,   cnt_cycle_d;
    logic [CNT_W-1:0] cnt_instret_q, cnt_instret_d;

    instr_class_t     w_cls;
    logic             w_legal;
    logic             w_tmo_hit;

    mc_instr_class #(
        .EN_JAL (EN_JAL)
    ) u_instr_class (
        .ir_i    (ir_q),
        .cls_o   (w_cls),
        .legal_o (w_legal)
    );

    // Expiry is judged on the cycle whose increment would reach TIMEOUT; a valid in that cycle still wins.
    assign w_tmo_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wb_sel_d  = wb_sel_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        err_d     = err_q;
        wait_d    = wait_q;

        unique case (state_q)
            ST_F: begin
                if (ctrl_if.imem_resp_valid) begin
                    ir_d    = ctrl_if.imem_resp_data;
                    state_d = ST_D;
                end else if (w_tmo_hit) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_D: begin
                if (!w_legal) begin
                    state_d   = ST_F;
                    illegal_d = 1'b1;
                end else begin
                    case (w_cls)
                        CLS_NOP, CLS_JUMP: begin
                            state_d  = ST_F;
                            retire_d = 1'b1;
                        end
                        CLS_JAL: begin
                            state_d  = ST_W;
                            wb_sel_d = WB_LINK;
                        end
                        default: state_d = ST_E;
                    endcase
                end
            end
            ST_E: begin
                case (w_cls)
                    CLS_BRANCH: begin
                        state_d  = ST_F;
                        retire_d = 1'b1;
                    end
                    CLS_ALU: begin
                        state_d  = ST_W;
                        wb_sel_d = WB_ALU;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_M;
                    default:             state_d = ST_F;
                endcase
            end
            ST_M: begin
                if (ctrl_if.dmem_resp_valid) begin
                    if (w_cls == CLS_LOAD) begin
                        state_d  = ST_W;
                        wb_sel_d = WB_MEM;
                    end else begin
                        state_d  = ST_F;
                        retire_d = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_W: begin
                state_d  = ST_F;
                retire_d = 1'b1;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_F;
            end
        endcase

        if ((state_d != state_q) && ((state_d == ST_F) || (state_d == ST_M))) begin
            wait_d = '0;
        end
    end

    assign cnt_cycle_d   = (state_q != ST_ERR) ? cnt_cycle_q + CNT_W'(1) : cnt_cycle_q;
    assign cnt_instret_d = retire_d ? cnt_instret_q + CNT_W'(1) : cnt_instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_F;
            ir_q          <= '0;
            wb_sel_q      <= WB_ALU;
            retire_q      <= 1'b0;
            illegal_q     <= 1'b0;
            err_q         <= 1'b0;
            wait_q        <= '0;
            cnt_cycle_q   <= '0;
            cnt_instret_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            wb_sel_q      <= wb_sel_d;
            retire_q      <= retire_d;
            illegal_q     <= illegal_d;
            err_q         <= err_d;
            wait_q        <= wait_d;
            cnt_cycle_q   <= cnt_cycle_d;
            cnt_instret_q <= cnt_instret_d;
        end
    end

    assign ctrl_if.imem_req    = (state_q == ST_F);
    assign ctrl_if.dmem_req    = (state_q == ST_M);
    assign ctrl_if.stage_en    = stage_onehot(state_q);
    assign ctrl_if.ir          = ir_q;
    assign ctrl_if.wb_sel      = wb_sel_q;
    assign ctrl_if.retire      = retire_q;
    assign ctrl_if.illegal     = illegal_q;
    assign ctrl_if.err         = err_q;
    assign ctrl_if.cnt_cycle   = cnt_cycle_q;
    assign ctrl_if.cnt_instret = cnt_instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_mc_ctrl_fsm : scoreboard bench for the multicycle control FSM
// Rev 1.0
// ------------------------------------------------------------------
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0008;
    localparam logic [31:0] I_ADDI = 32'h2042_0001;
    localparam logic [31:0] I_ORI  = 32'h3442_00FF;
    localparam logic [31:0] I_RADD = 32'h0022_1820;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_BNE  = 32'h1422_0003;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    localparam logic [4:0] S_F = 5'b00001;
    localparam logic [4:0] S_D = 5'b00010;
    localparam logic [4:0] S_E = 5'b00100;
    localparam logic [4:0] S_M = 5'b01000;
    localparam logic [4:0] S_W = 5'b10000;

    typedef struct {
        logic ill;
        int   cyc;
        int   instret;
    } exp_t;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    int          n_chk;
    int          n_fail;
    int          tb_cyc;
    int          model_instret;
    logic [31:0] last_ir;
    exp_t        sb_q[$];

    mc_ctrl_fsm_if #(.CNT_W(4))  ifa ();
    mc_ctrl_fsm_if #(.CNT_W(32)) ifb ();

    mc_ctrl_fsm #(.EN_JAL(1'b1), .TIMEOUT(4), .CNT_W(4)) dut_a (
        .clk     (clk),
        .reset   (rst_a),
        .ctrl_if (ifa)
    );

    mc_ctrl_fsm #(.EN_JAL(1'b0), .TIMEOUT(0), .CNT_W(32)) dut_b (
        .clk     (clk),
        .reset   (rst_b),
        .ctrl_if (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic mon_a();
        exp_t e;
        if (ifa.retire || ifa.illegal) begin
            check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_retire",  ifa.retire,  !e.ill);
                check("sb_illegal", ifa.illegal, e.ill);
                check("sb_cnt_cycle",   ifa.cnt_cycle,   32'(e.cyc % 16));
                check("sb_cnt_instret", ifa.cnt_instret, 32'(e.instret));
            end
        end
    endtask

    task automatic step_a();
        @(posedge clk);
        #1;
        tb_cyc++;
        mon_a();
    endtask

    task automatic do_reset_a();
        #2;
        rst_a = 1'b1;
        #1;
        check("rst_stage_en", ifa.stage_en, S_F);
        check("rst_imem_req", ifa.imem_req, 1'b1);
        check("rst_dmem_req", ifa.dmem_req, 1'b0);
        check("rst_ir",       ifa.ir, 32'h0);
        check("rst_wb_sel",   ifa.wb_sel, 2'd0);
        check("rst_retire",   ifa.retire, 1'b0);
        check("rst_illegal",  ifa.illegal, 1'b0);
        check("rst_err",      ifa.err, 1'b0);
        check("rst_cnt_cycle",   ifa.cnt_cycle, 4'd0);
        check("rst_cnt_instret", ifa.cnt_instret, 4'd0);
        @(posedge clk);
        #1;
        rst_a         = 1'b0;
        tb_cyc        = 0;
        model_instret = 0;
        last_ir       = 32'h0;
        sb_q.delete();
    endtask

    // Leaves the DUT one cycle past D; the completion is queued at drive time.
    task automatic fetch_a(input logic [31:0] instr, input int iwait, input int len,
                           input int dwait, input logic ill);
        exp_t e;
        e.ill = ill;
        e.cyc = tb_cyc + iwait + dwait + len;
        if (!ill) model_instret = (model_instret + 1) % 16;
        e.instret = model_instret;
        sb_q.push_back(e);
        for (int i = 0; i < iwait; i++) begin
            check("f_wait_stage", ifa.stage_en, S_F);
            check("f_wait_ir",    ifa.ir, last_ir);
            ifa.imem_resp_valid = 1'b0;
            ifa.imem_resp_data  = $urandom;
            step_a();
        end
        check("f_stage",    ifa.stage_en, S_F);
        check("f_imem_req", ifa.imem_req, 1'b1);
        ifa.imem_resp_valid = 1'b1;
        ifa.imem_resp_data  = instr;
        step_a();
        ifa.imem_resp_valid = 1'b0;
        ifa.imem_resp_data  = $urandom;
        last_ir = instr;
        check("d_stage", ifa.stage_en, S_D);
        check("d_ir",    ifa.ir, instr);
        step_a();
    endtask

    task automatic expect_st(input string tag, input logic [4:0] st);
        check(tag, ifa.stage_en, st);
        step_a();
    endtask

    task automatic mem_a(input int dwait);
        for (int i = 0; i < dwait; i++) begin
            check("m_wait_stage", ifa.stage_en, S_M);
            check("m_dmem_req",   ifa.dmem_req, 1'b1);
            ifa.dmem_resp_valid = 1'b0;
            step_a();
        end
        check("m_stage", ifa.stage_en, S_M);
        ifa.dmem_resp_valid = 1'b1;
        step_a();
        ifa.dmem_resp_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; tb_cyc = 0; model_instret = 0; last_ir = 32'h0;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.imem_resp_valid = 1'b0; ifa.imem_resp_data = 32'h0; ifa.dmem_resp_valid = 1'b0;
        ifb.imem_resp_valid = 1'b0; ifb.imem_resp_data = 32'h0; ifb.dmem_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset_a();

        // LW with both memories ready immediately; dmem valid stays high outside M too
        ifa.dmem_resp_valid = 1'b1;
        fetch_a(I_LW, 0, 5, 0, 1'b0);
        expect_st("lw_e", S_E);
        mem_a(0);
        check("lw_wb_sel", ifa.wb_sel, 2'd1);
        expect_st("lw_w", S_W);
        check("lw_back_f", ifa.stage_en, S_F);

        // ADDI with a 3-cycle imem delay, then a mix of classes without reset
        do_reset_a();
        fetch_a(I_ADDI, 3, 4, 0, 1'b0);
        expect_st("addi_e", S_E);
        check("addi_wb_sel", ifa.wb_sel, 2'd0);
        expect_st("addi_w", S_W);

        fetch_a(I_JAL, 0, 3, 0, 1'b0);
        check("jal_wb_sel", ifa.wb_sel, 2'd2);
        expect_st("jal_w", S_W);
        check("jal_wb_hold", ifa.wb_sel, 2'd2);

        fetch_a(I_ORI, 0, 4, 0, 1'b0);
        check("ori_wb_hold_e", ifa.wb_sel, 2'd2);
        expect_st("ori_e", S_E);
        check("ori_wb_sel", ifa.wb_sel, 2'd0);
        expect_st("ori_w", S_W);

        fetch_a(I_BEQ, 0, 3, 0, 1'b0);
        expect_st("beq_e", S_E);
        fetch_a(I_BNE, 1, 3, 0, 1'b0);
        expect_st("bne_e", S_E);
        fetch_a(I_J, 0, 2, 0, 1'b0);
        fetch_a(I_RADD, 2, 4, 0, 1'b0);
        expect_st("radd_e", S_E);
        expect_st("radd_w", S_W);
        fetch_a(I_BAD, 0, 2, 0, 1'b1);
        fetch_a(I_NOP, 0, 2, 0, 1'b0);

        // SW whose data response lands on the last permitted wait cycle
        fetch_a(I_SW, 0, 4, 3, 1'b0);
        expect_st("sw_e", S_E);
        mem_a(3);
        check("sw_no_err", ifa.err, 1'b0);
        check("sw_back_f", ifa.stage_en, S_F);

        // 16 back-to-back NOPs wrap the 4-bit retire counter
        do_reset_a();
        for (int i = 0; i < 16; i++) fetch_a(I_NOP, 0, 2, 0, 1'b0);
        check("nop_wrap_instret", ifa.cnt_instret, 4'd0);
        check("nop_wrap_cycle",   ifa.cnt_cycle,   4'd0);

        // Reset asserted while in D
        ifa.imem_resp_valid = 1'b1;
        ifa.imem_resp_data  = I_LW;
        step_a();
        ifa.imem_resp_valid = 1'b0;
        check("midd_stage", ifa.stage_en, S_D);
        #2;
        rst_a = 1'b1;
        #1;
        check("midd_rst_stage", ifa.stage_en, S_F);
        check("midd_rst_ir",    ifa.ir, 32'h0);
        do_reset_a();

        // SW with no data response: timeout into ERR, then recovery by reset
        ifa.imem_resp_valid = 1'b1;
        ifa.imem_resp_data  = I_SW;
        step_a();
        ifa.imem_resp_valid = 1'b0;
        step_a();
        step_a();
        for (int i = 0; i < 4; i++) begin
            check("tmo_m_stage", ifa.stage_en, S_M);
            check("tmo_m_err",   ifa.err, 1'b0);
            step_a();
        end
        check("tmo_err",       ifa.err, 1'b1);
        check("tmo_stage_en",  ifa.stage_en, 5'd0);
        check("tmo_imem_req",  ifa.imem_req, 1'b0);
        check("tmo_dmem_req",  ifa.dmem_req, 1'b0);
        check("tmo_cnt_cycle", ifa.cnt_cycle, 4'd7);
        ifa.imem_resp_valid = 1'b1;
        ifa.dmem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) step_a();
        ifa.imem_resp_valid = 1'b0;
        ifa.dmem_resp_valid = 1'b0;
        check("err_sticky",         ifa.err, 1'b1);
        check("err_stage_en",       ifa.stage_en, 5'd0);
        check("err_cnt_cycle_frz",  ifa.cnt_cycle, 4'd7);
        check("err_cnt_instret",    ifa.cnt_instret, 4'd0);
        do_reset_a();
        check("post_err_stage", ifa.stage_en, S_F);
        check("post_err_err",   ifa.err, 1'b0);

        // EN_JAL=0, timeout disabled
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        ifb.imem_resp_valid = 1'b1;
        ifb.imem_resp_data  = I_JAL;
        @(posedge clk);
        #1;
        ifb.imem_resp_valid = 1'b0;
        check("b_jal_d", ifb.stage_en, S_D);
        @(posedge clk);
        #1;
        check("b_jal_illegal",  ifb.illegal, 1'b1);
        check("b_jal_retire",   ifb.retire, 1'b0);
        check("b_jal_stage",    ifb.stage_en, S_F);
        check("b_jal_instret",  ifb.cnt_instret, 32'd0);
        check("b_jal_cycle",    ifb.cnt_cycle, 32'd2);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        check("b_long_wait_err",   ifb.err, 1'b0);
        check("b_long_wait_stage", ifb.stage_en, S_F);
        ifb.imem_resp_valid = 1'b1;
        ifb.imem_resp_data  = I_ADDI;
        @(posedge clk);
        #1;
        ifb.imem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("b_addi_retire",  ifb.retire, 1'b1);
        check("b_addi_instret", ifb.cnt_instret, 32'd1);
        check("b_addi_cycle",   ifb.cnt_cycle, 32'd26);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
